// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - shared command and violation encodings for the DDR4 timing checker
package ddr_pkg;

    typedef enum logic [3:0] {
        CMD_DES, CMD_NOP, CMD_ACT, CMD_MRS, CMD_REF,
        CMD_PRE, CMD_PREA, CMD_RD, CMD_WR, CMD_ZQ
    } cmd_e;

    typedef enum logic [3:0] {
        V_NONE       = 4'd0,
        V_TRCD       = 4'd1,
        V_TRP        = 4'd2,
        V_TRAS       = 4'd3,
        V_TRRD       = 4'd4,
        V_TCCD       = 4'd5,
        V_TWTR       = 4'd6,
        V_TRTP       = 4'd7,
        V_TWR        = 4'd8,
        V_ACT_OPEN   = 4'd9,
        V_CAS_CLOSED = 4'd10,
        V_TREFI      = 4'd11,
        V_REF_OPEN   = 4'd12
    } viol_e;

    localparam int NUM_CODES = 13;

    // cs_n high is a deselect; act_n low overrides the RAS/CAS/WE pins, which then carry row address.
    function automatic cmd_e decode_cmd(input logic cs_n, input logic act_n,
                                        input logic [2:0] rcw, input logic a10);
        cmd_e c;
        if (cs_n) begin
            c = CMD_DES;
        end else if (!act_n) begin
            c = CMD_ACT;
        end else begin
            case (rcw)
                3'b000:  c = CMD_MRS;
                3'b001:  c = CMD_REF;
                3'b010:  c = a10 ? CMD_PREA : CMD_PRE;
                3'b100:  c = CMD_WR;
                3'b101:  c = CMD_RD;
                3'b110:  c = CMD_ZQ;
                default: c = CMD_NOP;  // 111 is NOP, 011 is reserved and treated alike
            endcase
        end
        return c;
    endfunction

    // A counter of N means the reference event happened N+1 cycles before this command.
    function automatic logic too_soon(input int cnt, input int limit);
        return (cnt + 1) < limit;
    endfunction

endpackage

// File: rtl/ddr_bank_timer.sv
// rtl/ddr_bank_timer.sv - per-bank open state, elapsed-cycle counters and timing fail flags
module ddr_bank_timer
    import ddr_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int tRCD  = 9,
    parameter int tRP   = 9,
    parameter int tRAS  = 28,
    parameter int tRTP  = 6,
    parameter int tWR_T = 22
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic act_i,
    input  logic pre_i,
    input  logic rd_i,
    input  logic wr_i,
    output logic open_o,
    output logic fail_rcd_o,
    output logic fail_rp_o,
    output logic fail_ras_o,
    output logic fail_rtp_o,
    output logic fail_wr_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             open_q, open_d;
    logic [CNT_W-1:0] act_cnt_q, act_cnt_d;
    logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic             pre_take;

    function automatic logic [CNT_W-1:0] bump(input logic clr, input logic [CNT_W-1:0] cnt);
        if (clr) return '0;
        return (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    endfunction

    // Precharging a closed bank is a no-op: it neither closes anything nor restarts tRP.
    assign pre_take = pre_i && open_q;

    // Next bank state and counter values for this command cycle.
    always_comb begin
        open_d = open_q;
        if (act_i) begin
            open_d = 1'b1;
        end else if (pre_take) begin
            open_d = 1'b0;
        end
        act_cnt_d = bump(act_i, act_cnt_q);
        pre_cnt_d = bump(pre_take, pre_cnt_q);
        rd_cnt_d  = bump(rd_i, rd_cnt_q);
        wr_cnt_d  = bump(wr_i, wr_cnt_q);
    end

    // Counters start saturated so the first command after reset never trips a spacing rule.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            open_q    <= 1'b0;
            act_cnt_q <= CNT_MAX;
            pre_cnt_q <= CNT_MAX;
            rd_cnt_q  <= CNT_MAX;
            wr_cnt_q  <= CNT_MAX;
        end else begin
            open_q    <= open_d;
            act_cnt_q <= act_cnt_d;
            pre_cnt_q <= pre_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    assign open_o     = open_q;
    assign fail_rcd_o = too_soon(int'(act_cnt_q), tRCD);
    assign fail_rp_o  = too_soon(int'(pre_cnt_q), tRP);
    // Precharge rules only matter when the precharge actually closes the bank.
    assign fail_ras_o = open_q && too_soon(int'(act_cnt_q), tRAS);
    assign fail_rtp_o = open_q && too_soon(int'(rd_cnt_q), tRTP);
    assign fail_wr_o  = open_q && too_soon(int'(wr_cnt_q), tWR_T);

endmodule

// File: rtl/ddr_timing_checker.sv
// rtl/ddr_timing_checker.sv - DDR4 command-bus timing and protocol monitor
module ddr_timing_checker
    import ddr_pkg::*;
#(
    parameter int NUM_BG = 2,
    parameter int NUM_BA = 4,
    parameter int CNT_W  = 8,
    parameter int REF_W  = 16,
    parameter int tRCD   = 9,
    parameter int tRP    = 9,
    parameter int tRAS   = 28,
    parameter int tRRD   = 4,
    parameter int tCCD   = 4,
    parameter int tWTR_T = 16,
    parameter int tRTP   = 6,
    parameter int tWR_T  = 22,
    parameter int tREFI  = 6240,
    localparam int NB    = NUM_BG * NUM_BA,
    localparam int BG_W  = (NUM_BG > 1) ? $clog2(NUM_BG) : 1,
    localparam int BA_W  = (NUM_BA > 1) ? $clog2(NUM_BA) : 1,
    localparam int NB_W  = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic            CK_t,
    input  logic            reset_n,
    input  logic            cs_n,
    input  logic            act_n,
    input  logic            RAS_n_A16,
    input  logic            CAS_n_A15,
    input  logic            WE_n_A14,
    input  logic            A10,
    input  logic [BG_W-1:0] bg_addr,
    input  logic [BA_W-1:0] ba_addr,
    input  logic            chk_en,
    output logic            viol,
    output logic [3:0]      viol_code,
    output logic [NB_W-1:0] viol_bank,
    output logic [15:0]     err_cnt,
    output logic [NB-1:0]   bank_open
);

    cmd_e             cmd;
    logic [NB_W-1:0]  cmd_bank;
    logic [NB-1:0]    sel, pre_sel;
    logic             is_act, is_pre, is_prea, is_rd, is_wr, is_cas, is_ref;
    logic [NB-1:0]    f_rcd, f_rp, f_ras, f_rtp, f_wr;

    logic [CNT_W-1:0] act_g_q, act_g_d, cas_g_q, cas_g_d, wr_g_q, wr_g_d;
    logic [REF_W-1:0] ref_q, ref_d;
    logic             refi_flag_q, refi_flag_d, refi_due;

    logic [NB-1:0]    hit [NUM_CODES];
    viol_e            code_sel;
    logic [NB_W-1:0]  bank_sel;

    logic             viol_q, viol_d;
    viol_e            viol_code_q, viol_code_d;
    logic [NB_W-1:0]  viol_bank_q, viol_bank_d;
    logic [15:0]      err_cnt_q, err_cnt_d;

    assign cmd      = decode_cmd(cs_n, act_n, {RAS_n_A16, CAS_n_A15, WE_n_A14}, A10);
    assign cmd_bank = NB_W'((int'(bg_addr) % NUM_BG) * NUM_BA + (int'(ba_addr) % NUM_BA));
    assign sel      = NB'(1) << cmd_bank;
    assign is_act   = (cmd == CMD_ACT);
    assign is_pre   = (cmd == CMD_PRE);
    assign is_prea  = (cmd == CMD_PREA);
    assign is_rd    = (cmd == CMD_RD);
    assign is_wr    = (cmd == CMD_WR);
    assign is_cas   = is_rd || is_wr;
    assign is_ref   = (cmd == CMD_REF);
    assign pre_sel  = {NB{is_prea}} | ({NB{is_pre}} & sel);

    for (genvar b = 0; b < NB; b++) begin : g_bank
        ddr_bank_timer #(
            .CNT_W (CNT_W),
            .tRCD  (tRCD),
            .tRP   (tRP),
            .tRAS  (tRAS),
            .tRTP  (tRTP),
            .tWR_T (tWR_T)
        ) u_timer (
            .clk_i      (CK_t),
            .rst_ni     (reset_n),
            .act_i      (is_act && sel[b]),
            .pre_i      (pre_sel[b]),
            .rd_i       (is_rd && sel[b]),
            .wr_i       (is_wr && sel[b]),
            .open_o     (bank_open[b]),
            .fail_rcd_o (f_rcd[b]),
            .fail_rp_o  (f_rp[b]),
            .fail_ras_o (f_ras[b]),
            .fail_rtp_o (f_rtp[b]),
            .fail_wr_o  (f_wr[b])
        );
    end

    // Refresh overdue fires once per interval; the flag re-arms only on the next REF.
    assign refi_due = (int'(ref_q) >= tREFI) && !refi_flag_q;

    // Global cross-bank counters and the refresh-interval tracker.
    always_comb begin
        act_g_d     = is_act ? '0 : ((act_g_q == '1) ? act_g_q : act_g_q + 1'b1);
        cas_g_d     = is_cas ? '0 : ((cas_g_q == '1) ? cas_g_q : cas_g_q + 1'b1);
        wr_g_d      = is_wr  ? '0 : ((wr_g_q  == '1) ? wr_g_q  : wr_g_q  + 1'b1);
        ref_d       = is_ref ? '0 : ((ref_q   == '1) ? ref_q   : ref_q   + 1'b1);
        refi_flag_d = is_ref ? 1'b0 : (refi_flag_q | refi_due);
    end

    // Violation matrix: one row per code, one column per bank that the rule blames.
    always_comb begin
        hit = '{default: '0};
        for (int b = 0; b < NB; b++) begin
            hit[V_TRCD][b]       = is_cas && sel[b] && f_rcd[b];
            hit[V_TRP][b]        = is_act && sel[b] && f_rp[b];
            hit[V_TRAS][b]       = pre_sel[b] && f_ras[b];
            hit[V_TRRD][b]       = is_act && sel[b] && too_soon(int'(act_g_q), tRRD);
            hit[V_TCCD][b]       = is_cas && sel[b] && too_soon(int'(cas_g_q), tCCD);
            hit[V_TWTR][b]       = is_rd && sel[b] && too_soon(int'(wr_g_q), tWTR_T);
            hit[V_TRTP][b]       = pre_sel[b] && f_rtp[b];
            hit[V_TWR][b]        = pre_sel[b] && f_wr[b];
            hit[V_ACT_OPEN][b]   = is_act && sel[b] && bank_open[b];
            hit[V_CAS_CLOSED][b] = is_cas && sel[b] && !bank_open[b];
            hit[V_TREFI][b]      = (b == 0) && refi_due;
            hit[V_REF_OPEN][b]   = is_ref && bank_open[b];
        end
    end

    // Walk codes and banks from the top down so the lowest code and lowest bank win last.
    always_comb begin
        code_sel = V_NONE;
        bank_sel = '0;
        for (int c = NUM_CODES - 1; c >= 1; c--) begin
            if (|hit[c]) begin
                code_sel = viol_e'(4'(c));
                for (int b = NB - 1; b >= 0; b--) begin
                    if (hit[c][b]) bank_sel = NB_W'(b);
                end
            end
        end
    end

    // Report stage: masked by chk_en, with a saturating error tally.
    always_comb begin
        viol_d      = chk_en && (code_sel != V_NONE);
        viol_code_d = viol_d ? code_sel : V_NONE;
        viol_bank_d = viol_d ? bank_sel : '0;
        err_cnt_d   = (viol_d && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;
    end

    // Global counters start saturated; the refresh interval starts counting from reset.
    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            act_g_q     <= '1;
            cas_g_q     <= '1;
            wr_g_q      <= '1;
            ref_q       <= '0;
            refi_flag_q <= 1'b0;
        end else begin
            act_g_q     <= act_g_d;
            cas_g_q     <= cas_g_d;
            wr_g_q      <= wr_g_d;
            ref_q       <= ref_d;
            refi_flag_q <= refi_flag_d;
        end
    end

    // Registered violation outputs, visible one cycle after the offending command.
    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            viol_q      <= 1'b0;
            viol_code_q <= V_NONE;
            viol_bank_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            viol_q      <= viol_d;
            viol_code_q <= viol_code_d;
            viol_bank_q <= viol_bank_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign viol      = viol_q;
    assign viol_code = viol_code_q;
    assign viol_bank = viol_bank_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ddr_timing_checker.sv
// tb/tb_ddr_timing_checker.sv - self-checking bench for ddr_timing_checker
module tb_ddr_timing_checker;
    import ddr_pkg::*;

    localparam int NB     = 8;
    localparam int T_RCD  = 9;
    localparam int T_RP   = 9;
    localparam int T_RAS  = 28;
    localparam int T_RRD  = 4;
    localparam int T_CCD  = 4;
    localparam int T_WTR  = 16;
    localparam int T_RTP  = 6;
    localparam int T_WR   = 22;
    localparam int T_REFI = 6240;
    localparam int NEVER  = -1000000;

    logic        CK_t = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs_n = 1'b1, act_n = 1'b1, RAS_n_A16 = 1'b1, CAS_n_A15 = 1'b1, WE_n_A14 = 1'b1;
    logic        A10 = 1'b0, chk_en = 1'b1;
    logic [0:0]  bg_addr = '0;
    logic [1:0]  ba_addr = '0;
    logic        viol;
    logic [3:0]  viol_code;
    logic [2:0]  viol_bank;
    logic [15:0] err_cnt;
    logic [7:0]  bank_open;

    int total = 0;
    int bad   = 0;

    ddr_timing_checker dut (
        .CK_t      (CK_t),
        .reset_n   (reset_n),
        .cs_n      (cs_n),
        .act_n     (act_n),
        .RAS_n_A16 (RAS_n_A16),
        .CAS_n_A15 (CAS_n_A15),
        .WE_n_A14  (WE_n_A14),
        .A10       (A10),
        .bg_addr   (bg_addr),
        .ba_addr   (ba_addr),
        .chk_en    (chk_en),
        .viol      (viol),
        .viol_code (viol_code),
        .viol_bank (viol_bank),
        .err_cnt   (err_cnt),
        .bank_open (bank_open)
    );

    always #5 CK_t = ~CK_t;

    // Reference model: absolute cycle stamps of the last event of each kind.
    bit m_open [NB];
    int m_act [NB], m_pre [NB], m_rd [NB], m_wr [NB];
    int m_gact, m_gcas, m_gwr, m_refbase, m_err, m_now, m_best;
    bit m_refrep;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, m_now, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            m_open[b] = 1'b0;
            m_act[b] = NEVER; m_pre[b] = NEVER; m_rd[b] = NEVER; m_wr[b] = NEVER;
        end
        m_gact = NEVER; m_gcas = NEVER; m_gwr = NEVER;
        m_refbase = 0; m_refrep = 1'b0; m_err = 0; m_now = 0;
    endtask

    task automatic note(input int c, input int b);
        if (c * 16 + b < m_best) m_best = c * 16 + b;
    endtask

    function automatic logic [7:0] open_vec();
        logic [7:0] v;
        for (int b = 0; b < NB; b++) v[b] = m_open[b];
        return v;
    endfunction

    task automatic model_step(input cmd_e c, input int bk, input bit en,
                              output int ev, output int ec, output int eb);
        m_best = 1000;
        case (c)
            CMD_ACT: begin
                if (m_now - m_pre[bk] < T_RP) note(2, bk);
                if (m_now - m_gact < T_RRD)   note(4, bk);
                if (m_open[bk])               note(9, bk);
            end
            CMD_RD, CMD_WR: begin
                if (m_now - m_act[bk] < T_RCD)              note(1, bk);
                if (m_now - m_gcas < T_CCD)                 note(5, bk);
                if (c == CMD_RD && m_now - m_gwr < T_WTR)   note(6, bk);
                if (!m_open[bk])                            note(10, bk);
            end
            CMD_PRE, CMD_PREA: begin
                for (int b = 0; b < NB; b++) begin
                    if (m_open[b] && (c == CMD_PREA || b == bk)) begin
                        if (m_now - m_act[b] < T_RAS) note(3, b);
                        if (m_now - m_rd[b] < T_RTP)  note(7, b);
                        if (m_now - m_wr[b] < T_WR)   note(8, b);
                    end
                end
            end
            CMD_REF: begin
                for (int b = 0; b < NB; b++) if (m_open[b]) note(12, b);
            end
            default: ;
        endcase
        if (m_now - m_refbase >= T_REFI && !m_refrep) begin
            note(11, 0);
            m_refrep = 1'b1;
        end
        ev = (en && m_best < 1000) ? 1 : 0;
        ec = ev ? m_best / 16 : 0;
        eb = ev ? m_best % 16 : 0;
        if (ev != 0 && m_err < 65535) m_err++;
        case (c)
            CMD_ACT: begin m_open[bk] = 1'b1; m_act[bk] = m_now; m_gact = m_now; end
            CMD_RD:  begin m_rd[bk] = m_now; m_gcas = m_now; end
            CMD_WR:  begin m_wr[bk] = m_now; m_gcas = m_now; m_gwr = m_now; end
            CMD_PRE: if (m_open[bk]) begin m_open[bk] = 1'b0; m_pre[bk] = m_now; end
            CMD_PREA: begin
                for (int b = 0; b < NB; b++)
                    if (m_open[b]) begin m_open[b] = 1'b0; m_pre[b] = m_now; end
            end
            CMD_REF: begin m_refrep = 1'b0; m_refbase = m_now + 1; end
            default: ;
        endcase
        m_now++;
    endtask

    task automatic drive(input cmd_e c, input int bank);
        logic [2:0] rcw;
        rcw   = 3'($urandom);
        cs_n  = 1'b0;
        act_n = 1'b1;
        A10   = 1'($urandom);
        bg_addr = 1'(bank / 4);
        ba_addr = 2'(bank % 4);
        case (c)
            CMD_DES:  begin cs_n = 1'b1; act_n = 1'($urandom); end
            CMD_ACT:  act_n = 1'b0;
            CMD_NOP:  rcw = 3'b111;
            CMD_MRS:  rcw = 3'b000;
            CMD_REF:  rcw = 3'b001;
            CMD_PRE:  begin rcw = 3'b010; A10 = 1'b0; end
            CMD_PREA: begin rcw = 3'b010; A10 = 1'b1; end
            CMD_WR:   rcw = 3'b100;
            CMD_RD:   rcw = 3'b101;
            CMD_ZQ:   rcw = 3'b110;
            default:  ;
        endcase
        {RAS_n_A16, CAS_n_A15, WE_n_A14} = rcw;
    endtask

    // Called at a falling edge; returns at the next falling edge with outputs checked.
    task automatic do_cycle(input cmd_e c, input int bank, input bit en);
        int ev, ec, eb;
        drive(c, bank);
        chk_en = en;
        model_step(c, bank, en, ev, ec, eb);
        @(posedge CK_t);
        #1;
        check_eq("viol", viol, ev);
        check_eq("viol_code", viol_code, ec);
        check_eq("viol_bank", viol_bank, eb);
        check_eq("err_cnt", err_cnt, m_err);
        check_eq("bank_open", bank_open, open_vec());
        @(negedge CK_t);
    endtask

    task automatic idle(input int n);
        repeat (n) do_cycle(CMD_DES, 0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge CK_t);
        reset_n = 1'b0;
        drive(CMD_DES, 0);
        repeat (2) @(negedge CK_t);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int pulses, code_seen, r;
        cmd_e c;
        model_reset();

        do_reset();
        check_eq("rst_viol", viol, 0);
        check_eq("rst_code", viol_code, 0);
        check_eq("rst_bank", viol_bank, 0);
        check_eq("rst_err", err_cnt, 0);
        check_eq("rst_open", bank_open, 0);

        do_cycle(CMD_ACT, 0, 1'b1);
        do_cycle(CMD_ACT, 1, 1'b1);
        check_eq("trrd_viol", viol, 1);
        check_eq("trrd_code", viol_code, 4);
        check_eq("trrd_bank", viol_bank, 1);
        idle(7);
        do_cycle(CMD_RD, 0, 1'b1);
        check_eq("rd_at_trcd_clean", viol, 0);

        do_reset();
        do_cycle(CMD_ACT, 0, 1'b1);
        idle(4);
        do_cycle(CMD_WR, 0, 1'b1);
        check_eq("trcd_code", viol_code, 1);
        check_eq("trcd_bank", viol_bank, 0);
        check_eq("trcd_err", err_cnt, 1);

        do_reset();
        do_cycle(CMD_ACT, 0, 1'b1);
        idle(19);
        do_cycle(CMD_PRE, 0, 1'b1);
        check_eq("tras_code", viol_code, 3);
        idle(4);
        do_cycle(CMD_ACT, 0, 1'b1);
        check_eq("trp_code", viol_code, 2);
        check_eq("trp_open0", bank_open[0], 1);
        check_eq("trp_err", err_cnt, 2);

        do_reset();
        do_cycle(CMD_ACT, 2, 1'b1);
        idle(39);
        do_cycle(CMD_WR, 2, 1'b1);
        check_eq("wr_clean", viol, 0);
        idle(3);
        do_cycle(CMD_RD, 2, 1'b1);
        check_eq("twtr_code", viol_code, 6);
        check_eq("twtr_bank", viol_bank, 2);

        do_reset();
        do_cycle(CMD_ACT, 0, 1'b1);
        idle(3);
        do_cycle(CMD_ACT, 3, 1'b1);
        idle(27);
        do_cycle(CMD_PREA, 0, 1'b1);
        check_eq("prea_clean", viol, 0);
        check_eq("prea_closed", bank_open, 0);
        idle(7);
        do_cycle(CMD_REF, 0, 1'b1);
        check_eq("ref_clean", viol, 0);

        do_reset();
        do_cycle(CMD_ACT, 5, 1'b1);
        idle(3);
        do_cycle(CMD_ACT, 2, 1'b1);
        idle(5);
        do_cycle(CMD_PREA, 0, 1'b1);
        check_eq("prea_tras_code", viol_code, 3);
        check_eq("prea_low_bank", viol_bank, 2);

        do_reset();
        do_cycle(CMD_ACT, 0, 1'b1);
        do_cycle(CMD_ACT, 1, 1'b0);
        check_eq("chk_off_viol", viol, 0);
        check_eq("chk_off_err", err_cnt, 0);

        do_reset();
        pulses = 0;
        code_seen = 0;
        for (int i = 0; i < T_REFI + 60; i++) begin
            do_cycle(CMD_DES, 0, 1'b1);
            if (viol) begin pulses++; code_seen = viol_code; end
        end
        check_eq("trefi_pulses", pulses, 1);
        check_eq("trefi_code", code_seen, 11);

        do_cycle(CMD_ACT, 0, 1'b1);
        do_cycle(CMD_ACT, 1, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_viol", viol, 0);
        check_eq("async_code", viol_code, 0);
        check_eq("async_bank", viol_bank, 0);
        check_eq("async_err", err_cnt, 0);
        check_eq("async_open", bank_open, 0);
        drive(CMD_DES, 0);
        @(negedge CK_t);
        reset_n = 1'b1;
        model_reset();
        do_cycle(CMD_ACT, 5, 1'b1);
        check_eq("post_rst_act", viol, 0);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if      (r < 30) c = CMD_DES;
            else if (r < 35) c = CMD_NOP;
            else if (r < 55) c = CMD_ACT;
            else if (r < 65) c = CMD_PRE;
            else if (r < 68) c = CMD_PREA;
            else if (r < 78) c = CMD_RD;
            else if (r < 88) c = CMD_WR;
            else if (r < 92) c = CMD_REF;
            else if (r < 95) c = CMD_MRS;
            else             c = CMD_ZQ;
            do_cycle(c, $urandom_range(0, NB - 1), ($urandom_range(0, 19) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
